rpc_init_seq: RTL and testbench

Register-bus master that runs the RPC DRAM controller's configuration sequence after reset. It sits directly upstream of the controller's reg-bus slave port, ahead of any software access. It waits out the DRAM power-up interval, issues a fixed list of configuration writes, then polls a status register until the controller reports ready. It flags completion or failure to the SoC, and software may re-run the sequence on demand.

---
 rtl/rpc_pkg.sv | 19 +
 rtl/rpc_init_seq_if.sv | 30 +++
 rtl/rpc_init_poll_ctr.sv | 51 +++++
 rtl/rpc_init_seq.sv | 184 ++++++++++++++++++
 tb/tb_rpc_init_seq.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpc_pkg.sv
// rtl/rpc_pkg.sv - shared types and controller register map for the RPC init sequencer
// Holds the sequencer state encoding and the controller's default register
// addresses so that parameter defaults elsewhere can refer to them.
package rpc_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_WRITE,
    ST_POLL,
    ST_POLL_GAP,
    ST_DONE,
    ST_ERROR
  } rpc_init_state_e;

  // Controller register map (reg-bus byte addresses).
  localparam logic [47:0] RPC_CFG_BASE_ADDR = 48'h0;
  localparam logic [47:0] RPC_STATUS_ADDR   = 48'h0;

endpackage

// File: rtl/rpc_init_seq_if.sv
// rtl/rpc_init_seq_if.sv - register bus between the init sequencer and the controller
// Signals:
//   addr/write/wdata/wstrb/valid : request, driven by the master
//   rdata/ready/error            : response, driven by the slave; ready completes
//                                  the transaction, rdata and error qualify it
interface rpc_init_seq_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error;

  modport master (
    output addr, write, wdata, wstrb, valid,
    input  rdata, ready, error
  );

  modport slave (
    input  addr, write, wdata, wstrb, valid,
    output rdata, ready, error
  );

endinterface

// File: rtl/rpc_init_poll_ctr.sv
// rtl/rpc_init_poll_ctr.sv - status poll compare and retry counter
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart the retry count (entering the poll phase)
//   rsp_i         : a status read completed without a bus error
//   rdata_i       : read data of that status read
//   match_o       : all StatusMask bits are set in rdata_i
//   timeout_o     : a non-matching response now would use up the last retry
module rpc_init_poll_ctr #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] StatusMask  = DATA_WIDTH'(1),
  parameter int                    PollTimeout = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  rsp_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  match_o,
  output logic                  timeout_o
);

  localparam int CntW = $clog2(PollTimeout + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PollTimeout);

  logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
  logic [CntW-1:0] poll_cnt_inc;

  assign poll_cnt_inc = poll_cnt_q + CntW'(1);
  assign match_o      = (rdata_i & StatusMask) == StatusMask;
  assign timeout_o    = (poll_cnt_inc == CntMax);

  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (clr_i) begin
      poll_cnt_d = '0;
    end else if (rsp_i && !match_o && (poll_cnt_q != CntMax)) begin
      // Saturates at the limit; the sequencer leaves POLL on reaching it.
      poll_cnt_d = poll_cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end

endmodule

// File: rtl/rpc_init_seq.sv
// rtl/rpc_init_seq.sv - RPC DRAM controller configuration sequencer (reg-bus master)
// Waits out DRAM power-up, writes InitAddr/InitData in index order, then polls
// StatusAddr until (rdata & StatusMask) == StatusMask or PollTimeout reads fail.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : re-run request, honoured only in DONE or ERROR
//   reg_bus        : register bus master port
//   init_done_o    : sequence completed successfully
//   init_error_o   : sequence failed (bus error or poll timeout)
//   busy_o         : sequence in progress
module rpc_init_seq
  import rpc_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 48,
  parameter int REG_DATA_WIDTH = 32,
  parameter int NumWrites      = 6,
  parameter logic [NumWrites-1:0][REG_ADDR_WIDTH-1:0] InitAddr =
    {NumWrites{REG_ADDR_WIDTH'(RPC_CFG_BASE_ADDR)}},
  parameter logic [NumWrites-1:0][REG_DATA_WIDTH-1:0] InitData = '0,
  parameter int PwrUpCycles    = 40000,
  parameter logic [REG_ADDR_WIDTH-1:0] StatusAddr = REG_ADDR_WIDTH'(RPC_STATUS_ADDR),
  parameter logic [REG_DATA_WIDTH-1:0] StatusMask = REG_DATA_WIDTH'(1),
  parameter int PollTimeout    = 1024
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  rpc_init_seq_if.master reg_bus,
  output logic           init_done_o,
  output logic           init_error_o,
  output logic           busy_o
);

  localparam int WaitW = (PwrUpCycles > 0) ? $clog2(PwrUpCycles + 1) : 1;
  localparam int IdxW  = (NumWrites > 1) ? $clog2(NumWrites) : 1;
  localparam int StrbW = REG_DATA_WIDTH / 8;
  localparam logic [WaitW-1:0] WaitLast = (PwrUpCycles > 0) ? WaitW'(PwrUpCycles - 1) : '0;
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumWrites - 1);

  rpc_init_state_e state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic                      valid_q, valid_d;
  logic                      write_q, write_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]          wstrb_q, wstrb_d;

  logic rsp, rsp_ok, issue_wr, issue_rd;
  logic poll_clr, poll_rsp, poll_match, poll_timeout;

  assign rsp      = valid_q & reg_bus.ready;
  assign rsp_ok   = rsp & ~reg_bus.error;
  assign poll_clr = (state_q == ST_WRITE) && rsp_ok && (idx_q == IdxLast);
  assign poll_rsp = (state_q == ST_POLL) && rsp_ok;

  rpc_init_poll_ctr #(
    .DATA_WIDTH  (REG_DATA_WIDTH),
    .StatusMask  (StatusMask),
    .PollTimeout (PollTimeout)
  ) u_poll_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (poll_clr),
    .rsp_i     (poll_rsp),
    .rdata_i   (reg_bus.rdata),
    .match_o   (poll_match),
    .timeout_o (poll_timeout)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;

    unique case (state_q)
      ST_PWRUP: begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if ((PwrUpCycles == 0) || (wait_cnt_q == WaitLast)) begin
          state_d = ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        // Entered from PWRUP with nothing outstanding: present the first write.
        if (!valid_q) begin
          issue_wr = 1'b1;
        end else if (reg_bus.ready) begin
          if (reg_bus.error) begin
            valid_d = 1'b0;
            state_d = ST_ERROR;
          end else if (idx_q == IdxLast) begin
            valid_d = 1'b0;
            state_d = ST_POLL;
          end else begin
            idx_d    = idx_q + IdxW'(1);
            issue_wr = 1'b1;
          end
        end
      end
      ST_POLL: begin
        // First poll after the last write starts one idle cycle later.
        if (!valid_q) begin
          issue_rd = 1'b1;
        end else if (reg_bus.ready) begin
          valid_d = 1'b0;
          if (reg_bus.error)     state_d = ST_ERROR;
          else if (poll_match)   state_d = ST_DONE;
          else if (poll_timeout) state_d = ST_ERROR;
          else                   state_d = ST_POLL_GAP;
        end
      end
      ST_POLL_GAP: begin
        issue_rd = 1'b1;
        state_d  = ST_POLL;
      end
      ST_DONE, ST_ERROR: begin
        // Re-run skips the power-up wait and presents write 0 immediately.
        if (start_i) begin
          state_d  = ST_WRITE;
          idx_d    = '0;
          issue_wr = 1'b1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    if (issue_wr) begin
      valid_d = 1'b1;
      write_d = 1'b1;
      addr_d  = InitAddr[idx_d];
      wdata_d = InitData[idx_d];
      wstrb_d = '1;
    end
    if (issue_rd) begin
      valid_d = 1'b1;
      write_d = 1'b0;
      addr_d  = StatusAddr;
      wstrb_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_PWRUP;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign reg_bus.valid = valid_q;
  assign reg_bus.write = write_q;
  assign reg_bus.addr  = addr_q;
  assign reg_bus.wdata = wdata_q;
  assign reg_bus.wstrb = wstrb_q;

  assign init_done_o  = (state_q == ST_DONE);
  assign init_error_o = (state_q == ST_ERROR);
  assign busy_o       = (state_q == ST_PWRUP) || (state_q == ST_WRITE) ||
                        (state_q == ST_POLL)  || (state_q == ST_POLL_GAP);

endmodule

// File: tb/tb_rpc_init_seq.sv
// tb/tb_rpc_init_seq.sv - directed self-checking bench for rpc_init_seq
module tb_rpc_init_seq;

  localparam int PWR = 10;
  localparam int NW  = 3;
  localparam int PT  = 8;

  logic clk = 1'b0;
  logic rst_ni;
  logic start;
  logic init_done_o, init_error_o, busy_o;

  always #5 clk = ~clk;

  rpc_init_seq_if #(.ADDR_WIDTH(48), .DATA_WIDTH(32)) bus ();

  rpc_init_seq #(
    .REG_ADDR_WIDTH (48),
    .REG_DATA_WIDTH (32),
    .NumWrites      (NW),
    .InitAddr       ({48'h30, 48'h20, 48'h10}),
    .InitData       ({32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}),
    .PwrUpCycles    (PWR),
    .StatusAddr     (48'h100),
    .StatusMask     (32'h1),
    .PollTimeout    (PT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start),
    .reg_bus      (bus),
    .init_done_o  (init_done_o),
    .init_error_o (init_error_o),
    .busy_o       (busy_o)
  );

  // Hand-written expected write sequence.
  logic [47:0] exp_addr [0:2] = '{48'h10, 48'h20, 48'h30};
  logic [31:0] exp_data [0:2] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
  localparam logic [47:0] EXP_STAT = 48'h100;

  // Cycle counter: the edge on which reset is released is cycle 0.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Slave model.
  int slv_wait = 0;
  int slv_cnt = 0;
  int reads_done = 0;
  int rd_base = 0;
  int zeros_before = 0;
  logic err_en = 1'b0;
  logic [47:0] err_addr = 48'h0;

  always @(posedge clk) begin
    if (!bus.valid || bus.ready) slv_cnt <= 0;
    else                         slv_cnt <= slv_cnt + 1;
    if (bus.valid && bus.ready && !bus.write) reads_done <= reads_done + 1;
  end

  assign bus.ready = bus.valid && (slv_cnt >= slv_wait);
  assign bus.error = err_en && bus.valid && bus.write && (bus.addr == err_addr);
  assign bus.rdata = ((reads_done - rd_base) >= zeros_before) ? 32'h1 : 32'h0;

  // Transaction log and request-stability monitor.
  typedef struct {
    int          c;
    logic        wr;
    logic [47:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;
  txn_t log_q[$];

  int stab_err = 0;
  logic pv = 1'b0, pr = 1'b0, pw = 1'b0;
  logic [47:0] pa = '0;
  logic [31:0] pd = '0;
  logic [3:0]  ps = '0;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (pv && !pr) begin
        if (!bus.valid || bus.addr != pa || bus.wdata != pd || bus.write != pw || bus.wstrb != ps)
          stab_err <= stab_err + 1;
      end
      if (bus.valid && bus.ready)
        log_q.push_back('{cyc, bus.write, bus.addr, bus.wdata, bus.wstrb});
    end
    pv <= bus.valid & rst_ni;
    pr <= bus.ready;
    pw <= bus.write;
    pa <= bus.addr;
    pd <= bus.wdata;
    ps <= bus.wstrb;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_end(output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done_o || init_error_o) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " valid after start"}, bus.valid, 1);
    check({tag, " busy after start"}, busy_o, 1);
    check({tag, " done cleared"}, init_done_o, 0);
    check({tag, " error cleared"}, init_error_o, 0);
  endtask

  task automatic check_writes(input string tag, input int b);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s wr%0d addr", tag, i), log_q[b+i].addr, exp_addr[i]);
      check($sformatf("%s wr%0d data", tag, i), log_q[b+i].data, exp_data[i]);
      check($sformatf("%s wr%0d write", tag, i), log_q[b+i].wr, 1);
      check($sformatf("%s wr%0d strb", tag, i), log_q[b+i].strb, 4'hF);
    end
  endtask

  task automatic check_reads(input string tag, input int b, input int n);
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s rd%0d addr", tag, j), log_q[b+j].addr, EXP_STAT);
      check($sformatf("%s rd%0d write", tag, j), log_q[b+j].wr, 0);
      check($sformatf("%s rd%0d strb", tag, j), log_q[b+j].strb, 4'h0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b;
    rst_ni = 1'b0;
    start  = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst valid", bus.valid, 0);
    check("rst write", bus.write, 0);
    check("rst addr", bus.addr, 0);
    check("rst wdata", bus.wdata, 0);
    check("rst wstrb", bus.wstrb, 0);
    check("rst done", init_done_o, 0);
    check("rst error", init_error_o, 0);
    check("rst busy", busy_o, 1);

    // Test 1: zero-wait slave, status matches on the first read.
    @(posedge clk);
    #1 rst_ni = 1'b1;
    b = log_q.size();
    wait_valid(c);
    check("t1 first valid cycle", c, 11);
    wait_end(c);
    check("t1 done cycle", c, 16);
    check("t1 done", init_done_o, 1);
    check("t1 error", init_error_o, 0);
    check("t1 busy", busy_o, 0);
    check("t1 txn count", log_q.size() - b, 4);
    check_writes("t1", b);
    check_reads("t1", b + 3, 1);
    check("t1 wr0 cycle", log_q[b].c, 11);
    check("t1 wr2 cycle", log_q[b+2].c, 13);
    check("t1 rd0 cycle", log_q[b+3].c, 15);

    // Test 2: three wait cycles per access.
    slv_wait = 3;
    b = log_q.size();
    pulse_start("t2");
    wait_end(c);
    check("t2 done", init_done_o, 1);
    check("t2 txn count", log_q.size() - b, 4);
    check_writes("t2", b);
    check_reads("t2", b + 3, 1);
    check("t2 wr1 wait", log_q[b+1].c - log_q[b].c, 4);
    check("t2 request stable", stab_err, 0);

    // Test 3: four non-matching reads, then a match.
    slv_wait = 0;
    rd_base = reads_done;
    zeros_before = 4;
    b = log_q.size();
    pulse_start("t3");
    wait_end(c);
    check("t3 done", init_done_o, 1);
    check("t3 error", init_error_o, 0);
    check("t3 txn count", log_q.size() - b, 8);
    check_reads("t3", b + 3, 5);
    for (int j = 1; j < 5; j++)
      check($sformatf("t3 rd gap %0d", j), log_q[b+3+j].c - log_q[b+2+j].c, 2);

    // Test 4: status never matches, timeout after exactly PT reads.
    rd_base = reads_done;
    zeros_before = 1000;
    b = log_q.size();
    pulse_start("t4");
    wait_end(c);
    check("t4 error", init_error_o, 1);
    check("t4 done", init_done_o, 0);
    check("t4 busy", busy_o, 0);
    check("t4 txn count", log_q.size() - b, 3 + 8);
    check_reads("t4", b + 3, 8);

    // Test 5: bus error on write index 1, then a clean re-run.
    rd_base = reads_done;
    zeros_before = 0;
    err_en = 1'b1;
    err_addr = 48'h20;
    b = log_q.size();
    pulse_start("t5a");
    wait_end(c);
    check("t5a error", init_error_o, 1);
    check("t5a done", init_done_o, 0);
    check("t5a txn count", log_q.size() - b, 2);
    check("t5a last addr", log_q[log_q.size()-1].addr, 48'h20);
    repeat (3) @(negedge clk);
    check("t5a no further request", bus.valid, 0);
    err_en = 1'b0;
    b = log_q.size();
    pulse_start("t5b");
    wait_end(c);
    check("t5b done", init_done_o, 1);
    check("t5b txn count", log_q.size() - b, 4);
    check_writes("t5b", b);

    // Test 6: reset in the middle of write index 2.
    slv_wait = 3;
    pulse_start("t6");
    c = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.valid && bus.addr == 48'h30) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t6 reached wr2", (c >= 0), 1);
    #1 rst_ni = 1'b0;
    #1;
    check("t6 async valid", bus.valid, 0);
    check("t6 async addr", bus.addr, 0);
    check("t6 async wdata", bus.wdata, 0);
    check("t6 async wstrb", bus.wstrb, 0);
    check("t6 async busy", busy_o, 1);
    check("t6 async done", init_done_o, 0);
    slv_wait = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    b = log_q.size();
    wait_valid(c);
    check("t6 first valid cycle", c, 11);
    check("t6 first addr", bus.addr, 48'h10);
    wait_end(c);
    check("t6 done cycle", c, 16);
    check("t6 done", init_done_o, 1);
    check("t6 txn count", log_q.size() - b, 4);
    check_writes("t6", b);
    check("t6 request stable", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
